conv_window_buffer: RTL
=======================

# conv_window_buffer

- Streaming sliding-window generator upstream of the convolutional layer's inner-product units.
- Accepts one pixel per handshake in raster order (row 0 col 0 first) for an IMG_H x IMG_W frame.
- Keeps K-1 line buffers plus a KxK window register array.
- Each time a full KxK window lies inside the image (valid convolution, no padding), it emits the window as one flat D_WIDTH*K*K word, packed in the order the inner-product unit expects.

## Interface
- K, 3, kernel side; window has K*K elements.
- D_WIDTH, 8, pixel width in bits.
- IMG_W, 28, frame width in pixels; must be >= K.
- IMG_H, 28, frame height in pixels; must be >= K.
- clk  input  1  the block's one clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_data  input  D_WIDTH  pixel.
- in_valid  input  1  pixel present.
- in_ready  output  1  block accepts pixel this cycle.
- in_last  input  1  marks the final pixel of the frame (checked only with CONV_WIN_FRAME_CHECK_EN).
- out_data  output  D_WIDTH*K*K  window; element i = r*K+c at bits [D_WIDTH*i +: D_WIDTH].
  - r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
- out_valid  output  1  out_data holds a valid window.
- out_ready  input  1  consumer takes the window.
- frame_done  output  1  one-cycle pulse after the final window of a frame is accepted.
- frame_err  output  1  sticky; present only with CONV_WIN_FRAME_CHECK_EN.

## Operation
- An accept happens when in_valid && in_ready. Counters col (0..IMG_W-1) and row (0..IMG_H-1) describe the accepted pixel.
- On each accept:
  - Pixel enters line buffer 0.
  - Each line buffer's IMG_W-delayed output cascades into the next buffer.
  - The window shifts left one column; the new right column is {line K-2 out, ..., line 0 out, in_data}, top to bottom.
- A window is complete when row >= K-1 and col >= K-1. The window is registered into out_data and out_valid is set on the following edge.
- Windows straddling a row wrap (col < K-1) are never emitted. The window contents shift through them regardless.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1).
- col wraps IMG_W-1 -> 0 and increments row. On row = IMG_H-1, col = IMG_W-1, both counters return to 0, ready for the next frame with no idle cycle.
- Line-buffer contents are not cleared between frames; stale data only feeds windows that are never emitted.
- FSM (shared-package enum):
  - FILL: row < K-1. No output.
  - STREAM: emitting windows.
  - FLUSH: last pixel accepted, final window still waiting on out_ready.
  - FLUSH -> FILL when the final window handshakes; frame_done pulses on that same edge.
  - If the last pixel completes no pending window, the transition is immediate.
- No arithmetic is performed; the data path is pure storage.

## Timing
- Reset values: in_ready=0 while rst is high, then 1. out_valid=0, out_data=0, frame_done=0, frame_err=0, counters 0, state FILL.
- in_ready = !out_valid || out_ready (single output slot, full throughput).
- Latency: an accept at edge t that completes a window gives out_valid=1 after edge t (visible in cycle t+1).
- Throughput: one window per cycle when in_valid and out_ready stay high.
- Backpressure: while out_valid && !out_ready:
  - out_data is held stable.
  - in_ready=0, and no counters or buffers move.
- Simultaneous out handshake and new accept: out_data is replaced in the same edge and out_valid stays 1.
- An accept that completes no window while the output handshakes clears out_valid.
- Reset mid-frame: everything returns immediately to the reset state; a partially emitted frame is abandoned.

## Configuration
- CONV_WIN_FRAME_CHECK_EN defined:
  - in_last is compared against (row==IMG_H-1 && col==IMG_W-1) on every accept.
  - A mismatch sets frame_err, which is sticky until rst.
  - Data flow is unaffected.
- Not defined: in_last is ignored, frame_err does not exist, and no comparison logic is built.

## Structure
- Shared package conv_pkg:
  - conv_win_state_t enum (FILL, STREAM, FLUSH).
  - Function win_idx(r,c) = r*K+c.
  - Counter width constants via $clog2(IMG_W) and $clog2(IMG_H).
- Sub-module conv_line_buffer: a D_WIDTH x IMG_W shift register with enable, instantiated K-1 times in a generate loop.

## Test plan
- Sequential frame: K=3, IMG_W=IMG_H=4, D_WIDTH=8, pixel = row*4+col, in_valid and out_ready held high.
  - First out_valid in the cycle after the 11th accept (value 10), with elements i0..i8 = 0,1,2,4,5,6,8,9,10.
  - Exactly 4 windows; the last is 5,6,7,9,10,11,13,14,15.
  - frame_done pulses once.
- Backpressure: same frame, out_ready low for 5 cycles after the first window.
  - out_data is stable and in_ready=0 throughout; no window is lost or duplicated.
- Back-to-back frames: two frames with no gap. Frame 2's first window is correct (0,1,2,4,...), which shows stale data is harmless.
- Reset mid-frame: assert rst after 7 accepts, then send a full frame.
  - out_valid=0 immediately on reset.
  - Exactly 4 correct windows follow.
- Random in_valid/out_ready (50%) over 20 frames; every window matches a reference model.
- With CONV_WIN_FRAME_CHECK_EN: in_last on pixel 14 of 16 -> frame_err=1 and remains 1. A correct in_last leaves frame_err=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv_window_buffer sliding-window generator.
package conv_pkg;

   localparam int CONV_K       = 3;
   localparam int CONV_D_WIDTH = 8;
   localparam int CONV_IMG_W   = 28;
   localparam int CONV_IMG_H   = 28;

   localparam int CONV_COL_W = $clog2(CONV_IMG_W);
   localparam int CONV_ROW_W = $clog2(CONV_IMG_H);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } conv_win_state_t;

   // Flat position of window element (r, c) inside out_data, in element units.
   function automatic int win_idx(input int r, input int c, input int k = CONV_K);
      return r * k + c;
   endfunction

   // Counter width for a 0..n-1 counter, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_window_buffer_line_buffer.sv
// One image line of delay: a D_WIDTH x DEPTH shift register that advances only on en.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int D_WIDTH = CONV_D_WIDTH,
   parameter int DEPTH   = CONV_IMG_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [D_WIDTH-1:0] din,
   output logic [D_WIDTH-1:0] dout
);

   logic [D_WIDTH-1:0] sr [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (en) begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming KxK sliding-window generator (valid convolution, raster-order input).
// Optional in_last consistency check and sticky frame_err: define CONV_WIN_FRAME_CHECK_EN.
//
// state  | meaning
// FILL   | first K-1 rows of the frame arriving, no window possible yet
// STREAM | windows being emitted as pixels arrive
// FLUSH  | last pixel taken, final window waiting for out_ready
module conv_window_buffer
   import conv_pkg::*;
#(
   parameter int K       = CONV_K,
   parameter int D_WIDTH = CONV_D_WIDTH,
   parameter int IMG_W   = CONV_IMG_W,
   parameter int IMG_H   = CONV_IMG_H
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [D_WIDTH-1:0]     in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_last,
   output logic [D_WIDTH*K*K-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   frame_done
`ifdef CONV_WIN_FRAME_CHECK_EN
   ,
   output logic                   frame_err
`endif
);

   localparam int COL_BITS = cnt_w(IMG_W);
   localparam int ROW_BITS = cnt_w(IMG_H);
   localparam logic [COL_BITS-1:0] COL_LAST      = COL_BITS'(IMG_W - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST      = ROW_BITS'(IMG_H - 1);
   localparam logic [COL_BITS-1:0] COL_FIRST_WIN = COL_BITS'(K - 1);
   localparam logic [ROW_BITS-1:0] ROW_FIRST_WIN = ROW_BITS'(K - 1);
   localparam logic [ROW_BITS-1:0] ROW_FILL_LAST = ROW_BITS'(K - 2);

   conv_win_state_t     state;
   logic [COL_BITS-1:0] col;
   logic [ROW_BITS-1:0] row;
   logic                accept;
   logic                win_done;
   logic                last_px;

   logic [D_WIDTH-1:0]     lb_in   [K-1];
   logic [D_WIDTH-1:0]     lb_out  [K-1];
   logic [D_WIDTH-1:0]     col_new [K];
   logic [D_WIDTH-1:0]     win     [K][K];
   logic [D_WIDTH-1:0]     win_nxt [K][K];
   logic [D_WIDTH*K*K-1:0] out_nxt;

   // Single output slot: a new pixel may enter whenever that slot is free or draining.
   assign in_ready = !rst && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign win_done = (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);
   assign last_px  = (row == ROW_LAST) && (col == COL_LAST);

   // Line buffer 0 sees the live pixel; deeper buffers hold progressively older rows.
   for (genvar gi = 0; gi < K - 1; gi++) begin : g_line
      if (gi == 0) begin : g_head
         assign lb_in[gi] = in_data;
      end else begin : g_tail
         assign lb_in[gi] = lb_out[gi-1];
      end

      conv_line_buffer #(
         .D_WIDTH (D_WIDTH),
         .DEPTH   (IMG_W)
      ) u_line (
         .clk  (clk),
         .rst  (rst),
         .en   (accept),
         .din  (lb_in[gi]),
         .dout (lb_out[gi])
      );

      assign col_new[gi] = lb_out[K-2-gi];
   end
   assign col_new[K-1] = in_data;

   always_comb begin
      win_nxt = win;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) win_nxt[r][c] = win[r][c+1];
         win_nxt[r][K-1] = col_new[r];
      end
   end

   always_comb begin
      out_nxt = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            out_nxt[D_WIDTH*win_idx(r, c, K) +: D_WIDTH] = win_nxt[r][c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FILL;
         col        <= '0;
         row        <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         frame_done <= 1'b0;
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) win[r][c] <= '0;
         end
      end else begin
         frame_done <= 1'b0;

         // Row-wrap windows still shift through the register, they just never reach out_data.
         if (accept) begin
            win       <= win_nxt;
            out_valid <= win_done;
            if (win_done) out_data <= out_nxt;
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            FILL:    if (accept && col == COL_LAST && row == ROW_FILL_LAST) state <= STREAM;
            STREAM:  if (accept && last_px) state <= FLUSH;
            FLUSH: begin
               if (out_valid && out_ready) begin
                  state      <= FILL;
                  frame_done <= 1'b1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

`ifdef CONV_WIN_FRAME_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
      end else if (accept && (in_last != last_px)) begin
         frame_err <= 1'b1;
      end
   end
`else
   logic unused_in_last;
   assign unused_in_last = in_last;
`endif

endmodule
